// File: rtl/mmu_pkg.sv
// mmu_pkg: shared constants and FSM encoding for the translation walker.
package mmu_pkg;
    localparam int DEF_PAGE_BITS = 12;
    localparam int PTE_V = 0;
    localparam int PTE_W = 1;
    typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, RESP} state_t;
endpackage

// File: rtl/mmu_tlb.sv
// mmu_tlb: fully-associative TLB with combinational lookup and invalid-first/round-robin fill.
module mmu_tlb #(
    parameter int TLB_ENTRIES = 4,
    parameter int VPN_W       = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             hit,
    output logic [VPN_W-1:0] hit_pfn,
    output logic             hit_w,
    input  logic             fill,
    input  logic [VPN_W-1:0] fill_vpn,
    input  logic [VPN_W-1:0] fill_pfn,
    input  logic             fill_w
);
    localparam int IW = $clog2(TLB_ENTRIES);
    logic [TLB_ENTRIES-1:0] valid;
    logic [TLB_ENTRIES-1:0] wr;
    logic [VPN_W-1:0]       vpn [TLB_ENTRIES];
    logic [VPN_W-1:0]       pfn [TLB_ENTRIES];
    logic [IW-1:0]          rr;
    logic [IW-1:0]          victim;

    // A flush in the same cycle turns any lookup into a miss.
    always_comb begin
        hit     = 1'b0;
        hit_pfn = '0;
        hit_w   = 1'b0;
        for (int i = 0; i < TLB_ENTRIES; i++)
            if (valid[i] && vpn[i] == lookup_vpn) begin
                hit     = !flush;
                hit_pfn = pfn[i];
                hit_w   = wr[i];
            end
    end

    // Descending scan so the lowest free slot wins; falls back to the round-robin slot.
    always_comb begin
        victim = rr;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--)
            if (!valid[i]) victim = IW'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            rr    <= '0;
        end else if (flush) begin
            valid <= '0;
        end else if (fill) begin
            valid[victim] <= 1'b1;
            rr            <= rr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !flush) begin
            vpn[victim] <= fill_vpn;
            pfn[victim] <= fill_pfn;
            wr[victim]  <= fill_w;
        end
    end
endmodule

// File: rtl/mmu_ptw.sv
// mmu_ptw: translation responder; TLB lookup on accept, single-level PTE walk on miss.
module mmu_ptw
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 4,
    parameter int PAGE_BITS   = DEF_PAGE_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ptbr,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_va,
    input  logic        req_write,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_pa,
    output logic        rsp_fault
);
    localparam int VPN_W = 32 - PAGE_BITS;
    state_t           state, state_nx;
    logic [31:0]      va_q, pa_q, addr_q;
    logic             write_q, fault_q;
    logic             accept, pte_take, pte_fault, hit_fault, fill;
    logic             tlb_hit, tlb_w;
    logic [VPN_W-1:0] tlb_pfn, req_vpn, pte_pfn;
    logic             unused_pte;

    assign req_vpn    = req_va[31:PAGE_BITS];
    assign pte_pfn    = mem_rsp_data[31:PAGE_BITS];
    assign accept     = req_valid && state == IDLE;
    assign pte_take   = mem_rsp_valid && state == MEM_WAIT;
    assign hit_fault  = req_write && !tlb_w;
    assign pte_fault  = !mem_rsp_data[PTE_V] || (write_q && !mem_rsp_data[PTE_W]);
    assign fill       = pte_take && mem_rsp_data[PTE_V];
    assign unused_pte = ^mem_rsp_data[PAGE_BITS-1:2];

    mmu_tlb #(
        .TLB_ENTRIES(TLB_ENTRIES),
        .VPN_W      (VPN_W)
    ) u_tlb (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .lookup_vpn(req_vpn),
        .hit       (tlb_hit),
        .hit_pfn   (tlb_pfn),
        .hit_w     (tlb_w),
        .fill      (fill),
        .fill_vpn  (va_q[31:PAGE_BITS]),
        .fill_pfn  (pte_pfn),
        .fill_w    (mem_rsp_data[PTE_W])
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        req_ready     = state == IDLE;
        mem_req_valid = state == MEM_REQ;
        rsp_valid     = state == RESP;
        case (state)
            IDLE:     if (req_valid) state_nx = tlb_hit ? RESP : MEM_REQ;
            MEM_REQ:  if (mem_req_ready) state_nx = MEM_WAIT;
            MEM_WAIT: if (mem_rsp_valid) state_nx = RESP;
            RESP:     if (rsp_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Result registers are loaded speculatively from the TLB on accept and overwritten by the walk on a miss.
    always_ff @(posedge clk) begin
        if (rst) begin
            va_q    <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            pa_q    <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            va_q    <= req_va;
            write_q <= req_write;
            addr_q  <= ptbr + (32'(req_vpn) << 2);
            fault_q <= hit_fault;
            pa_q    <= hit_fault ? '0 : {tlb_pfn, req_va[PAGE_BITS-1:0]};
        end else if (pte_take) begin
            fault_q <= pte_fault;
            pa_q    <= pte_fault ? '0 : {pte_pfn, va_q[PAGE_BITS-1:0]};
        end
    end

    assign mem_req_addr = addr_q;
    assign rsp_pa       = pa_q;
    assign rsp_fault    = fault_q;
endmodule

// File: tb/tb_mmu_ptw.sv
// tb_mmu_ptw: randomized and directed checks of mmu_ptw against a page-table/TLB reference model.
module tb_mmu_ptw;
    localparam int N = 4;
    typedef struct packed {
        logic [19:0] vpn;
        logic [19:0] pfn;
        logic        w;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ptbr = '0;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_va = '0;
    logic        req_write = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_pa;
    logic        rsp_fault;

    int          checks = 0;
    int          errors = 0;
    ent_t        tlb_q[$];
    int          rr = 0;
    logic [31:0] pt [logic [19:0]];
    logic [31:0] got_pa;
    logic        got_fault, got_walk;

    mmu_ptw #(.TLB_ENTRIES(N), .PAGE_BITS(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .ptbr         (ptbr),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_va       (req_va),
        .req_write    (req_write),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_pa       (rsp_pa),
        .rsp_fault    (rsp_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pt_get(input logic [19:0] vpn);
        if (!pt.exists(vpn))
            pt[vpn] = {20'($urandom), 10'd0, 1'($urandom), ($urandom_range(0, 4) != 0)};
        return pt[vpn];
    endfunction

    function automatic int tlb_find(input logic [19:0] vpn);
        foreach (tlb_q[i])
            if (tlb_q[i].vpn == vpn) return i;
        return -1;
    endfunction

    task automatic model_fill(input ent_t e);
        if (tlb_q.size() < N) tlb_q.push_back(e);
        else tlb_q[rr] = e;
        rr = (rr + 1) % N;
    endtask

    task automatic drain;
        for (int i = 0; i < 20 && !req_ready; i++) begin
            rsp_ready = 1'b1;
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'b1;
            mem_rsp_data = '0;
            tick;
        end
        rsp_ready = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    task automatic do_flush;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        tlb_q.delete();
    endtask

    task automatic noise;
        mem_rsp_valid = 1'b1;
        mem_rsp_data = {20'($urandom), 12'h003};
        tick;
        mem_rsp_valid = 1'b0;
        check("noise_rsp", 32'(rsp_valid), 0);
        check("noise_idle", 32'(req_ready), 1);
    endtask

    task automatic access(input logic [31:0] va, input logic wr, input logic fl_acc, input logic fl_fill,
                          input int hold, output logic [31:0] o_pa, output logic o_fault, output logic o_walk);
        logic [19:0] vpn;
        logic [31:0] pte, exp_pa, exp_addr;
        logic        miss, exp_fault;
        int          idx;
        vpn = va[31:12];
        check("idle", 32'(req_ready), 1);
        if (!req_ready) drain;
        idx = tlb_find(vpn);
        miss = fl_acc || idx < 0;
        exp_fault = 1'b0;
        exp_pa = '0;
        if (!miss) begin
            exp_fault = wr && !tlb_q[idx].w;
            exp_pa = exp_fault ? 32'd0 : {tlb_q[idx].pfn, va[11:0]};
        end
        req_valid = 1'b1;
        req_va = va;
        req_write = wr;
        flush = fl_acc;
        tick;
        req_valid = 1'b0;
        flush = 1'b0;
        if (fl_acc) tlb_q.delete();
        o_walk = mem_req_valid;
        check("walk", 32'(mem_req_valid), 32'(miss));
        if (miss) begin
            pte = pt_get(vpn);
            exp_addr = ptbr + 32'(vpn) * 4;
            check("rsp_early", 32'(rsp_valid), 0);
            check("mem_addr", mem_req_addr, exp_addr);
            for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
                tick;
                check("mem_hold_v", 32'(mem_req_valid), 1);
                check("mem_hold_a", mem_req_addr, exp_addr);
            end
            mem_req_ready = 1'b1;
            tick;
            mem_req_ready = 1'b0;
            check("mem_req_drop", 32'(mem_req_valid), 0);
            repeat ($urandom_range(0, 3)) tick;
            mem_rsp_valid = 1'b1;
            mem_rsp_data = pte;
            flush = fl_fill;
            tick;
            mem_rsp_valid = 1'b0;
            mem_rsp_data = $urandom;
            flush = 1'b0;
            exp_fault = !pte[0] || (wr && !pte[1]);
            exp_pa = exp_fault ? 32'd0 : {pte[31:12], va[11:0]};
            if (fl_fill) tlb_q.delete();
            else if (pte[0]) model_fill('{vpn: vpn, pfn: pte[31:12], w: pte[1]});
        end
        check("rsp_valid", 32'(rsp_valid), 1);
        check("rsp_pa", rsp_pa, exp_pa);
        check("rsp_fault", 32'(rsp_fault), 32'(exp_fault));
        for (int i = 0; i < hold; i++) begin
            tick;
            check("hold_valid", 32'(rsp_valid), 1);
            check("hold_pa", rsp_pa, exp_pa);
            check("hold_fault", 32'(rsp_fault), 32'(exp_fault));
        end
        o_pa = rsp_pa;
        o_fault = rsp_fault;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        check("rsp_done", 32'(rsp_valid), 0);
        check("back_idle", 32'(req_ready), 1);
    endtask

    initial begin
        logic [19:0] rvpn;
        ptbr = 32'h0001_0000;
        repeat (2) tick;
        rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_mem_valid", 32'(mem_req_valid), 0);
        check("rst_mem_addr", mem_req_addr, 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_pa", rsp_pa, 0);
        check("rst_rsp_fault", 32'(rsp_fault), 0);

        pt[20'd3] = 32'h0004_5003;
        access(32'h0000_3ABC, 1'b0, 1'b0, 1'b0, 3, got_pa, got_fault, got_walk);
        check("plan_miss_pa", got_pa, 32'h0004_5ABC);
        check("plan_miss_walk", 32'(got_walk), 1);
        access(32'h0000_3FFF, 1'b1, 1'b0, 1'b0, 1, got_pa, got_fault, got_walk);
        check("plan_hit_pa", got_pa, 32'h0004_5FFF);
        check("plan_hit_walk", 32'(got_walk), 0);

        pt[20'd5] = 32'h0007_7001;
        access(32'h0000_5010, 1'b1, 1'b0, 1'b0, 1, got_pa, got_fault, got_walk);
        check("plan_wp_fault", 32'(got_fault), 1);
        check("plan_wp_pa", got_pa, 0);
        access(32'h0000_5010, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        check("plan_ro_pa", got_pa, 32'h0007_7010);
        check("plan_ro_walk", 32'(got_walk), 0);
        access(32'h0000_5010, 1'b1, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        check("plan_ro_wfault", 32'(got_fault), 1);
        check("plan_ro_wwalk", 32'(got_walk), 0);

        pt[20'd9] = 32'h0000_0000;
        for (int k = 0; k < 2; k++) begin
            access(32'h0000_9000, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
            check("plan_inv_fault", 32'(got_fault), 1);
            check("plan_inv_walk", 32'(got_walk), 1);
        end

        rst = 1'b1;
        tick;
        rst = 1'b0;
        tlb_q.delete();
        rr = 0;
        pt[20'd1] = 32'h0001_1003;
        pt[20'd2] = 32'h0002_2003;
        pt[20'd4] = 32'h0004_4001;
        for (int k = 1; k <= 5; k++)
            access(32'(k) << 12, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        access(32'h0000_1000, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        check("plan_evict_walk", 32'(got_walk), 1);
        for (int k = 3; k <= 5; k++) begin
            access(32'(k) << 12, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
            check("plan_keep_walk", 32'(got_walk), 0);
        end
        do_flush;
        access(32'h0000_4123, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        check("plan_flush_walk", 32'(got_walk), 1);
        check("plan_flush_pa", got_pa, 32'h0004_4123);
        do_flush;
        access(32'h0000_4000, 1'b0, 1'b0, 1'b1, 0, got_pa, got_fault, got_walk);
        access(32'h0000_4000, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        check("plan_fillflush_walk", 32'(got_walk), 1);
        noise;

        access(32'h0000_3000, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        pt[20'd7] = 32'h0007_0003;
        req_valid = 1'b1;
        req_va = 32'h0000_7000;
        req_write = 1'b0;
        tick;
        req_valid = 1'b0;
        check("mw_walk", 32'(mem_req_valid), 1);
        mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tlb_q.delete();
        rr = 0;
        check("mw_req_ready", 32'(req_ready), 1);
        check("mw_rsp_valid", 32'(rsp_valid), 0);
        check("mw_mem_valid", 32'(mem_req_valid), 0);
        check("mw_mem_addr", mem_req_addr, 0);
        check("mw_rsp_pa", rsp_pa, 0);
        check("mw_rsp_fault", 32'(rsp_fault), 0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data = pt[20'd7];
        tick;
        mem_rsp_valid = 1'b0;
        check("mw_stale", 32'(rsp_valid), 0);
        tick;
        check("mw_stale2", 32'(rsp_valid), 0);
        access(32'h0000_3000, 1'b0, 1'b0, 1'b0, 0, got_pa, got_fault, got_walk);
        check("mw_empty_walk", 32'(got_walk), 1);

        for (int i = 0; i < 300; i++) begin
            if (i % 64 == 0) ptbr = $urandom;
            if ($urandom_range(0, 19) == 0) do_flush;
            if ($urandom_range(0, 19) == 0) noise;
            rvpn = ($urandom_range(0, 7) == 0) ? 20'($urandom) : 20'($urandom_range(0, 9));
            access({rvpn, 12'($urandom)}, 1'($urandom), $urandom_range(0, 15) == 0,
                   $urandom_range(0, 15) == 0, int'($urandom_range(0, 3)), got_pa, got_fault, got_walk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mmu_ptw.md
Name: mmu_ptw

Overview:
Translation responder behind the pass-through MMU: it services VA->PA translation requests using a small fully-associative TLB and a single-level page-table walker. The block reads page-table entries (PTEs) through a memory read port. It returns either a physical address or a fault over a valid/ready response channel. The block sits between the core's MMU request path and the memory arbiter.

Parameters:
- TLB_ENTRIES, 4, number of fully-associative TLB entries (power of 2, >=2).
- PAGE_BITS, 12, page offset width; VPN and PFN are each 32-PAGE_BITS bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ptbr  in  32  page-table base; must be stable while busy
- flush  in  1  invalidate all TLB entries
- req_valid  in  1  translation request valid
- req_ready  out  1  block can accept a request
- req_va  in  32  virtual address
- req_write  in  1  request is a store
- mem_req_valid  out  1  PTE read request
- mem_req_ready  in  1  memory accepts the read
- mem_req_addr  out  32  PTE address
- mem_rsp_valid  in  1  PTE data valid (one-cycle pulse)
- mem_rsp_data  in  32  PTE: [31:PAGE_BITS]=PFN, bit1=W, bit0=V
- rsp_valid  out  1  translation result valid
- rsp_ready  in  1  consumer accepts the result
- rsp_pa  out  32  physical address; 0 when rsp_fault=1
- rsp_fault  out  1  page fault

Behaviour:
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP.
- req_ready = (state==IDLE). A request is accepted on req_valid && req_ready; va and write are registered on acceptance.
- TLB lookup is combinational on req_va in the accept cycle.
- Hit -> RESP on the next cycle, so rsp_valid is asserted 1 cycle after acceptance. pa = {PFN, va[PAGE_BITS-1:0]}. Fault if write && !W.
- Miss -> MEM_REQ. mem_req_addr = ptbr + (VPN<<2) (32-bit wrap, no overflow check). mem_req_valid is held with a stable address until mem_req_ready, then the FSM moves to MEM_WAIT.
- MEM_WAIT: on mem_rsp_valid, capture the PTE and go to RESP.
  - fault = !V || (write && !W).
  - If V=1, fill the TLB with {VPN, PFN, W}, including read-only pages. Faulting PTEs (V=0) are never filled.
- Replacement: a round-robin pointer over TLB_ENTRIES, advanced on each fill. An invalid entry is used first (lowest index) if one exists.
- RESP: rsp_valid, rsp_pa and rsp_fault are held stable until rsp_ready, then the FSM returns to IDLE. There is no back-to-back accept in the RESP->IDLE cycle.
- flush: all valid bits are clear on the next edge.
  - flush in an accept cycle makes the lookup a miss.
  - flush in the fill cycle drops the fill.
  - flush does not abort an in-flight walk.
- mem_rsp_valid outside MEM_WAIT is ignored.
- Reset (including mid-walk): state=IDLE, all TLB valid=0, round-robin pointer=0. Outputs after reset: req_ready=1, mem_req_valid=0, mem_req_addr=0, rsp_valid=0, rsp_pa=0, rsp_fault=0. A mem_rsp_valid arriving after reset is ignored.

Decomposition:
- Shared package mmu_pkg:
  - PAGE_BITS default
  - PTE bit positions (PTE_V=0, PTE_W=1)
  - FSM state encoding constants
- Sub-module mmu_tlb holds the entry storage, combinational lookup (hit, PFN, W), fill port with round-robin/invalid-first victim select, and flush.
- mmu_ptw holds the FSM and handshakes.

Test Plan:
- Miss then fill: ptbr=0x0001_0000, va=0x0000_3ABC, read -> mem_req_addr=0x0001_000C. Return PTE=0x0004_5003 -> rsp_pa=0x0004_5ABC, fault=0, held under rsp_ready=0 for 3 cycles.
- Hit: repeat va=0x0000_3FFF write -> no mem_req_valid; rsp_valid 1 cycle after accept, rsp_pa=0x0004_5FFF, fault=0.
- Write protection: va=0x0000_5010 write, PTE=0x0007_7001 -> fault=1, pa=0. A follow-up read of 0x0000_5010 hits (no walk) with pa=0x0007_7010. A follow-up write faults with no walk.
- Invalid PTE: va=0x0000_9000, PTE=0x0000_0000 -> fault=1. A repeat access walks again, because faulting PTEs are not cached.
- Replacement and flush: walk 5 distinct VPNs (1..5) with TLB_ENTRIES=4 -> VPN1 misses again, VPNs 3..5 hit. Assert flush -> next access to VPN4 walks. flush in the fill cycle -> a subsequent access to the same VPN walks.
- Reset mid-walk: rst during MEM_WAIT -> next cycle req_ready=1, rsp_valid=0, mem_req_valid=0. A stale mem_rsp_valid pulse produces no response. The TLB is empty afterwards.
